// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker execution unit.
// Contents:
//   OP_*          5-bit Tinker opcodes handled by the unit
//   state_e       handshake FSM states (IDLE / CALC / DONE)
//   md_mode_e     selects multiply or divide in the iterative engine
//   is_iterative  true for opcodes that use the multi-cycle engine
package tinker_pkg;

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_XOR   = 5'b00010;
   localparam logic [4:0] OP_NOT   = 5'b00011;
   localparam logic [4:0] OP_SHFTR = 5'b00100;
   localparam logic [4:0] OP_SHFTL = 5'b00110;
   localparam logic [4:0] OP_MOV   = 5'b10001;
   localparam logic [4:0] OP_MOVL  = 5'b10010;
   localparam logic [4:0] OP_ADD   = 5'b11000;
   localparam logic [4:0] OP_SUB   = 5'b11010;
   localparam logic [4:0] OP_MUL   = 5'b11100;
   localparam logic [4:0] OP_DIV   = 5'b11101;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   typedef enum logic {MD_MUL, MD_DIV} md_mode_e;

   function automatic logic is_iterative(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/tinker_exec_unit_if.sv
// Issue / write-back bus of the Tinker execution unit.
//   in_*   : operation offered by decode (valid/ready handshake)
//   out_*  : result presented to register-file write-back (valid/ready)
//   busy   : iterative operation in progress
// master = decode/write-back side, slave = execution unit.
interface tinker_exec_unit_if #(
   parameter int DATA_W = 64,
   parameter int LIT_W  = 12,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_opcode;
   logic [REG_AW-1:0] in_rd;
   logic [DATA_W-1:0] in_rs;
   logic [DATA_W-1:0] in_rt;
   logic [LIT_W-1:0]  in_lit;
   logic              out_valid;
   logic              out_ready;
   logic [REG_AW-1:0] out_rd;
   logic [DATA_W-1:0] out_result;
   logic              out_we;
   logic              out_div0;
   logic              busy;

   modport master (
      output in_valid, in_opcode, in_rd, in_rs, in_rt, in_lit, out_ready,
      input  in_ready, out_valid, out_rd, out_result, out_we, out_div0, busy
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_lit, out_ready,
      output in_ready, out_valid, out_rd, out_result, out_we, out_div0, busy
   );
endinterface

// File: rtl/tinker_iter_muldiv.sv
// Iterative unsigned multiply / divide engine, one bit per cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load operands and begin (counter := DATA_W)
//   mode       : MD_MUL (low DATA_W bits of a*b) or MD_DIV (quotient a/b)
//   a, b       : operands, sampled on start
//   done       : high during the cycle whose edge performs the last step
//   result     : value after that last step (valid while done is high)
module tinker_iter_muldiv
   import tinker_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  md_mode_e          mode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] result
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   // x: multiplicand (shifts left) / dividend-then-quotient (shifts left)
   // y: multiplier (shifts right)  / divisor (constant)
   // p: product accumulator        / partial remainder
   logic [CNT_W-1:0]  count_q, count_d;
   md_mode_e          mode_q, mode_d;
   logic [DATA_W-1:0] x_q, x_d, y_q, y_d, p_q, p_d;
   logic [DATA_W:0]   rem_sh, diff;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      count_d = count_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      p_d     = p_q;
      rem_sh  = {p_q, x_q[DATA_W-1]};
      diff    = rem_sh - {1'b0, y_q};
      if (start) begin
         count_d = CNT_W'(DATA_W);
         mode_d  = mode;
         x_d     = a;
         y_d     = b;
         p_d     = '0;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
         if (mode_q == MD_MUL) begin
            p_d = p_q + (y_q[0] ? x_q : '0);
            x_d = x_q << 1;
            y_d = y_q >> 1;
         end else if (!diff[DATA_W]) begin
            // restoring step: subtraction did not borrow, keep it
            p_d = diff[DATA_W-1:0];
            x_d = {x_q[DATA_W-2:0], 1'b1};
         end else begin
            p_d = rem_sh[DATA_W-1:0];
            x_d = {x_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign done   = (count_q == CNT_W'(1));
   assign result = (mode_q == MD_MUL) ? p_d : x_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         mode_q  <= MD_MUL;
         x_q     <= '0;
         y_q     <= '0;
         p_q     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
         count_q <= count_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         p_q     <= p_d;
      end
   end
endmodule

// File: rtl/tinker_exec_unit.sv
// Tinker integer execution unit: valid/ready issue, single-cycle ALU ops
// with latency 1, iterative mul/div with latency DATA_W+1, result held
// until write-back accepts it.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : tinker_exec_unit_if.slave (issue, result, busy)
module tinker_exec_unit
   import tinker_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int LIT_W  = 12,
   parameter int REG_AW = 5
) (
   input  logic clk,
   input  logic rst_n,
   tinker_exec_unit_if.slave bus
);
   localparam int SH_W = $clog2(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              we_q, we_d, div0_q, div0_d;
   logic [DATA_W-1:0] single_res, md_result;
   logic              single_ok, accept, div_by_zero, md_start, md_done;
   md_mode_e          md_mode;

   assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign md_mode      = (bus.in_opcode == OP_DIV) ? MD_DIV : MD_MUL;
   assign div_by_zero  = (bus.in_opcode == OP_DIV) && (bus.in_rt == '0);

   // Single-cycle datapath; single_ok=0 marks opcodes with no single-cycle result.
   always_comb begin
      single_res = '0;
      single_ok  = 1'b1;
      case (bus.in_opcode)
         OP_AND:   single_res = bus.in_rs & bus.in_rt;
         OP_OR:    single_res = bus.in_rs | bus.in_rt;
         OP_XOR:   single_res = bus.in_rs ^ bus.in_rt;
         OP_NOT:   single_res = ~bus.in_rs;
         OP_SHFTR: single_res = bus.in_rs >> bus.in_rt[SH_W-1:0];
         OP_SHFTL: single_res = bus.in_rs << bus.in_rt[SH_W-1:0];
         OP_ADD:   single_res = bus.in_rs + bus.in_rt;
         OP_SUB:   single_res = bus.in_rs - bus.in_rt;
         OP_MOV:   single_res = bus.in_rs;
         OP_MOVL:  single_res = {bus.in_rs[DATA_W-1:LIT_W], bus.in_lit};
         default:  single_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rd_d     = rd_q;
      we_d     = we_q;
      div0_d   = div0_q;
      md_start = 1'b0;
      case (state_q)
         CALC: begin
            if (md_done) begin
               state_d  = DONE;
               result_d = md_result;
            end
         end
         IDLE, DONE: begin
            if ((state_q == DONE) && bus.out_ready) state_d = IDLE;
            // accepting in DONE loads the new op directly, skipping IDLE
            if (accept) begin
               rd_d   = bus.in_rd;
               we_d   = 1'b1;
               div0_d = 1'b0;
               if (div_by_zero) begin
                  state_d  = DONE;
                  result_d = '1;
                  div0_d   = 1'b1;
               end else if (is_iterative(bus.in_opcode)) begin
                  state_d  = CALC;
                  md_start = 1'b1;
               end else begin
                  state_d  = DONE;
                  result_d = single_ok ? single_res : '0;
                  we_d     = single_ok;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
         div0_q   <= div0_d;
      end
   end

   tinker_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .mode   (md_mode),
      .a      (bus.in_rs),
      .b      (bus.in_rt),
      .done   (md_done),
      .result (md_result)
   );

   assign bus.out_valid  = (state_q == DONE);
   assign bus.busy       = (state_q == CALC);
   assign bus.out_rd     = rd_q;
   assign bus.out_result = result_q;
   assign bus.out_we     = we_q;
   assign bus.out_div0   = div0_q;
endmodule

// File: tb/tb_tinker_exec_unit.sv
// Directed self-checking bench for tinker_exec_unit (DATA_W=64).
module tb_tinker_exec_unit;
   import tinker_pkg::*;

   localparam int DATA_W = 64;
   localparam int LIT_W  = 12;
   localparam int REG_AW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tinker_exec_unit_if #(.DATA_W(DATA_W), .LIT_W(LIT_W), .REG_AW(REG_AW)) bus ();

   tinker_exec_unit #(.DATA_W(DATA_W), .LIT_W(LIT_W), .REG_AW(REG_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [REG_AW-1:0] rd,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [LIT_W-1:0] lit);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs     = a;
      bus.in_rt     = b;
      bus.in_lit    = lit;
   endtask

   // one-op issue: drive, take the accept edge, drop in_valid
   task automatic issue(input logic [4:0] op, input logic [REG_AW-1:0] rd,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [LIT_W-1:0] lit);
      drive(op, rd, a, b, lit);
      step();
      bus.in_valid = 1'b0;
   endtask

   // edges after the accept edge until out_valid, plus cycles seen busy with in_ready low
   task automatic run_iter(output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      while (!bus.out_valid && edges < 200) begin
         if (bus.busy && !bus.in_ready) busy_cycles++;
         step();
         edges++;
      end
   endtask

   initial begin
      int n, b, stable, spurious;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_rd     = '0;
      bus.in_rs     = '0;
      bus.in_rt     = '0;
      bus.in_lit    = '0;
      bus.out_ready = 1'b1;

      // reset state, checked before any clock edge
      #2;
      check("rst_out_valid",  64'(bus.out_valid), 64'd0);
      check("rst_busy",       64'(bus.busy), 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_out_rd",     64'(bus.out_rd), 64'd0);
      check("rst_out_we",     64'(bus.out_we), 64'd0);
      check("rst_out_div0",   64'(bus.out_div0), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);

      // add, then a back-to-back add accepted while the first result is presented
      drive(OP_ADD, 5'd3, 64'd5, 64'd7, '0);
      step();
      check("add_valid",  64'(bus.out_valid), 64'd1);
      check("add_result", bus.out_result, 64'd12);
      check("add_rd",     64'(bus.out_rd), 64'd3);
      check("add_we",     64'(bus.out_we), 64'd1);
      check("add_b2b_in_ready", 64'(bus.in_ready), 64'd1);
      drive(OP_ADD, 5'd4, 64'd20, 64'd22, '0);
      step();
      bus.in_valid = 1'b0;
      check("add2_result", bus.out_result, 64'd42);
      check("add2_rd",     64'(bus.out_rd), 64'd4);
      step();
      check("idle_after_drain", 64'(bus.out_valid), 64'd0);

      // div 100/7; operand inputs scrambled after accept
      issue(OP_DIV, 5'd6, 64'd100, 64'd7, '0);
      bus.in_rs = '1;
      bus.in_rt = 64'd1;
      run_iter(n, b);
      check("div_latency", 64'(n + 1), 64'd65);
      check("div_busy_cycles", 64'(b), 64'd64);
      check("div_result", bus.out_result, 64'd14);
      check("div_rd",     64'(bus.out_rd), 64'd6);
      check("div_div0",   64'(bus.out_div0), 64'd0);
      step();

      // divide by zero completes in one cycle
      issue(OP_DIV, 5'd2, 64'd9, 64'd0, '0);
      check("div0_valid",  64'(bus.out_valid), 64'd1);
      check("div0_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div0_flag",   64'(bus.out_div0), 64'd1);
      check("div0_we",     64'(bus.out_we), 64'd1);
      step();

      // multiply, including truncation of the high product bits
      issue(OP_MUL, 5'd8, 64'h0000_0000_FFFF_FFFF, 64'd3, '0);
      run_iter(n, b);
      check("mul_latency", 64'(n + 1), 64'd65);
      check("mul_result",  bus.out_result, 64'h0000_0002_FFFF_FFFD);
      step();
      issue(OP_MUL, 5'd8, 64'h8000_0000_0000_0000, 64'd2, '0);
      run_iter(n, b);
      check("mul_trunc_result", bus.out_result, 64'd0);
      check("mul_trunc_valid",  64'(bus.out_valid), 64'd1);
      step();

      // single-cycle datapath vectors
      issue(OP_MOVL, 5'd1, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 12'h123);
      check("movl_result", bus.out_result, 64'hAAAA_AAAA_AAAA_A123);
      check("movl_div0_cleared", 64'(bus.out_div0), 64'd0);
      step();
      issue(OP_SHFTL, 5'd1, 64'd1, 64'd65, '0);
      check("shftl_mod", bus.out_result, 64'd2);
      step();
      issue(OP_SHFTR, 5'd1, 64'h8000_0000_0000_0000, 64'd63, '0);
      check("shftr", bus.out_result, 64'd1);
      step();
      issue(OP_SUB, 5'd1, 64'd5, 64'd7, '0);
      check("sub_wrap", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      issue(OP_XOR, 5'd1, 64'hF0F0, 64'hFF00, '0);
      check("xor", bus.out_result, 64'h0FF0);
      step();
      issue(OP_NOT, 5'd1, 64'h0000_0000_FFFF_0000, 64'd0, '0);
      check("not", bus.out_result, 64'hFFFF_FFFF_0000_FFFF);
      step();
      issue(5'b01111, 5'd9, 64'd5, 64'd5, '0);
      check("unsup_valid",  64'(bus.out_valid), 64'd1);
      check("unsup_we",     64'(bus.out_we), 64'd0);
      check("unsup_result", bus.out_result, 64'd0);
      step();

      // backpressure: result held for 10 cycles while a new op waits
      bus.out_ready = 1'b0;
      issue(OP_ADD, 5'd7, 64'd1, 64'd2, '0);
      drive(OP_OR, 5'd9, 64'hF0, 64'h0F, '0);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid && bus.out_result == 64'd3 && bus.out_rd == 5'd7 && !bus.in_ready)
            stable++;
         step();
      end
      check("bp_stable_cycles", 64'(stable), 64'd10);
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      check("bp_next_result", bus.out_result, 64'hFF);
      check("bp_next_rd",     64'(bus.out_rd), 64'd9);
      step();

      // reset 30 cycles into a divide: aborts with no result afterwards
      issue(OP_DIV, 5'd5, 64'd1000, 64'd3, '0);
      repeat (29) step();
      check("mid_div_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy",      64'(bus.busy), 64'd0);
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (bus.out_valid) spurious++;
      end
      check("rst_no_result", 64'(spurious), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule

// File: doc/tinker_exec_unit.md
Name: tinker_exec_unit

Overview:
Parametrised, clocked integer execution unit for the Tinker core. It replaces the purely combinational ALU path with a valid/ready-handshaked unit. Single-cycle ops (logic, shift, add/sub, mov) are registered with 1-cycle latency. mul and div are iterative, one bit per cycle. The unit sits between decode/operand-read and register-file write-back, and passes the destination register tag through to write-back.

Parameters:
DATA_W, 64, operand/result width (power of 2, >=8)
LIT_W, 12, literal field width (< DATA_W)
REG_AW, 5, destination register tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept an operation this cycle
in_opcode  in  5  Tinker opcode
in_rd  in  REG_AW  destination tag
in_rs  in  DATA_W  operand A (current rd value for opcode 10010)
in_rt  in  DATA_W  operand B
in_lit  in  LIT_W  literal field
out_valid  out  1  result held
out_ready  in  1  write-back accepts result
out_rd  out  REG_AW  destination tag of result
out_result  out  DATA_W  result
out_we  out  1  write-back enable (0 for unsupported opcode)
out_div0  out  1  result came from divide by zero
busy  out  1  iterative op in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, out_we, out_div0, busy, out_result, out_rd all 0; counter 0. Clear applies immediately, with no clock required.
- FSM states: IDLE, CALC, DONE.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives full throughput for back-to-back single-cycle ops.
- Single-cycle opcodes, result in DONE on the next edge (latency 1):
  - 00000 and, 00001 or, 00010 xor, 00011 not (~A)
  - 00100 shftr (A >> B[log2 DATA_W-1:0]), 00110 shftl (A << same); shift amount is B modulo DATA_W; logical shifts
  - 11000 add, 11010 sub; wrap modulo 2^DATA_W, no flags
  - 10001 mov: result = A
  - 10010 mov literal: result = {A[DATA_W-1:LIT_W], lit}
- Unsupported opcode: go to DONE; out_we=0, out_result=0.
- div by zero (11101 with B==0): DONE in 1 cycle; result all ones; out_div0=1; out_we=1.
- Iterative ops:
  - 11100 mul: unsigned shift-add, low DATA_W bits of the product.
  - 11101 div: unsigned restoring, quotient only.
  - Both go to CALC with counter=DATA_W and busy=1. One bit per cycle; counter decrements.
  - At counter==1 the FSM goes to DONE. Accept-to-out_valid latency is exactly DATA_W+1 cycles.
- In DONE, out_valid=1. out_rd/out_result/out_we/out_div0 hold stable until out_ready=1.
- DONE with out_ready=1: if a new op is accepted the same cycle, load it (IDLE skipped); otherwise go to IDLE with out_valid=0.
- in_ready=0 during CALC and in DONE without out_ready. Inputs are ignored when not accepted.
- Operands and tag are captured at accept; later input changes have no effect.
- Reset mid-CALC aborts the operation; no result is produced.
- out_div0 is cleared on every new accept.

Decomposition:
- tinker_pkg:
  - opcode localparams/enum (OP_AND … OP_DIV)
  - state enum (IDLE/CALC/DONE)
  - function is_iterative(opcode)
- Sub-module tinker_iter_muldiv:
  - Inputs: start, mode, A, B.
  - Outputs: done, result.
  - Holds the shift registers and the counter.
  - tinker_exec_unit owns the FSM, handshake and single-cycle datapath.

Test Plan (DATA_W=64):
- add A=5, B=7, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=12, out_rd=3, out_we=1; second add issued back-to-back is accepted in that same cycle.
- div A=100, B=7 -> busy=1, in_ready=0 for 64 cycles; out_valid exactly 65 cycles after accept, out_result=14.
- div A=9, B=0 -> 1 cycle later out_result=0xFFFF_FFFF_FFFF_FFFF, out_div0=1.
- mul A=0xFFFF_FFFF, B=3 -> after 65 cycles out_result=0x2_FFFF_FFFD. Also mul A=2^63, B=2 -> 0 (truncation).
- mov literal A=0xAAAA_AAAA_AAAA_AAAA, lit=0x123 -> 0xAAAA_AAAA_AAAA_A123. shftl A=1, B=65 -> 2 (modulo). Opcode 01111 -> out_we=0, out_result=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after an add: result stable, in_ready=0.
  - Assert rst_n=0 mid-div at cycle 30: out_valid/busy drop immediately; no result after release.
